dmem_arbiter: RTL
=================

# dmem_arbiter

Two-port arbiter that shares the single-port data memory (Gowin BSRAM, 32-bit words, 11-bit word address, 1-cycle read latency) between the core load/store unit (port 0) and the debug/program loader (port 1). It sits between both requesters and the `bsram_dmem8k` instance. Each cycle it grants at most one access and converts byte addresses to word addresses. It rejects misaligned or out-of-range accesses and routes read data back to the requester that issued the read. Fixed priority favours the core, and a starvation counter guarantees loader progress.

## Interface
- `ADDR_W`, 11, word-address width of the memory (capacity 2^ADDR_W words)
- `STARVE_MAX`, 4, consecutive denied cycles of port 1 before it is forced to win (1..15)
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-low
- `m0_req`, `m1_req`  in  1  access request; hold with addr/we/wdata stable until gnt
- `m0_we`, `m1_we`  in  1  1 = write, 0 = read
- `m0_addr`, `m1_addr`  in  32  byte address
- `m0_wdata`, `m1_wdata`  in  32  write data
- `m0_gnt`, `m1_gnt`  out  1  request accepted this cycle (combinational)
- `m0_rvalid`, `m1_rvalid`  out  1  read data valid (one-cycle pulse)
- `m0_rdata`, `m1_rdata`  out  32  read data, 0 when rvalid=0
- `m0_err`, `m1_err`  out  1  one-cycle pulse: the access granted in the previous cycle was rejected
- `mem_ce`  out  1  memory access enable
- `mem_we`  out  1  memory write enable
- `mem_ad`  out  ADDR_W  word address
- `mem_din`  out  32  memory write data
- `mem_dout`  in  32  memory read data, valid one cycle after an accepted read

## Operation
- Arbitration (combinational, from req and starve counter):
  - Only one port requesting: that port is granted.
  - Both requesting: port 1 wins if `starve_cnt == STARVE_MAX`. Otherwise port 0 wins.
- Starve counter (registered, 4 bits):
  - Increments when m1_req=1 and m1_gnt=0. Saturates at STARVE_MAX.
  - Clears when m1 is granted or m1_req=0.
- Address check on the granted port:
  - Misaligned: `addr[1:0] != 0`.
  - Out of range: `addr[31:ADDR_W+2] != 0`.
  - Either fault: gnt is still asserted, mem_ce=0, mem_we=0, and the port's err pulses the next cycle. No rvalid. A faulting write is dropped.
- Valid access:
  - mem_ce=1, mem_we=we, mem_ad=addr[ADDR_W+1:2], mem_din=wdata.
- Read response pipeline (registered): `rd_pend` (1 bit) and `rd_sel` (port id) are captured at the grant.
  - Next cycle: the selected port gets rvalid=1 and rdata=mem_dout. The other port gets rdata=0.
- Writes produce no response. A write is complete at its grant edge.
- Idle (no req): mem_ce=0, mem_we=0. mem_ad, mem_din and gnt are all 0.

## Timing
- Grant and memory command occur in the same cycle N. Read data returns in cycle N+1.
- Throughput: one access per cycle. Back-to-back reads from either port are allowed, and responses return in order.
- Read after write to the same address issued in cycle N+1 returns the written data in N+2.
- Reset (rst=0, asynchronous):
  - starve_cnt=0, rd_pend=0, rd_sel=0, error flags=0.
  - gnt forced 0 and mem_ce/mem_we forced 0 for as long as rst=0.
  - rvalid=0, rdata=0, err=0.
- Reset mid-operation: a read granted before reset produces no rvalid after reset is released. The counter restarts from 0.
- Simultaneous requests with counter < STARVE_MAX: port 1 sees gnt=0 and must keep its request held.
- err and rvalid are never both 1 on the same port.

## Test plan
- Port 0 write 0x000000AB at addr 0x10, then read 0x10 -> write cycle: mem_ad=4, mem_we=1. Read: m0_rvalid=1 and m0_rdata=0x000000AB two cycles after the write grant.
- Both ports request continuously (STARVE_MAX=4) -> grants m0,m0,m0,m0,m1,m0,m0,m0,m0,m1,... port 1 granted every 5th cycle.
- Port 1 read at addr 0x6 -> m1_gnt=1, mem_ce=0. Next cycle m1_err=1, m1_rvalid=0.
- Port 0 write at addr 0x2000 (ADDR_W=11) -> m0_gnt=1, mem_ce=0, m0_err=1 next cycle. A subsequent read of word 0 shows memory unchanged.
- Port 0 reads 0x0 then 0x4 on consecutive cycles (memory 0x11, 0x22) -> m0_rvalid high two cycles, rdata 0x11 then 0x22. Interleaved m0/m1 reads route data to the correct port only.
- rst driven low the cycle after a port 1 read grant -> m1_rvalid stays 0, all outputs 0 during reset. After release, the first contended cycle grants m0.

Source files
------------

// File: rtl/dmem_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : dmem_arbiter
// Purpose  : Shares the single-port data BSRAM between the core LSU (port 0)
//            and the debug/program loader (port 1). Fixed priority to the
//            core with a starvation counter that forces a loader win, byte to
//            word address conversion, alignment/range rejection and read-data
//            routing back to the issuing port.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module dmem_arbiter #(
   parameter int ADDR_W     = 11,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,        // asynchronous, active-low
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [31:0]       m0_addr,
   input  logic [31:0]       m0_wdata,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic [31:0]       m0_rdata,
   output logic              m0_err,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [31:0]       m1_addr,
   input  logic [31:0]       m1_wdata,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [31:0]       m1_rdata,
   output logic              m1_err,
   output logic              mem_ce,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_ad,
   output logic [31:0]       mem_din,
   input  logic [31:0]       mem_dout
);

   localparam logic [3:0] c_starve_max = 4'(STARVE_MAX);

   logic [3:0]  r_starve_cnt;
   logic        r_rd_pend;
   logic        r_rd_sel;
   logic        r_err0;
   logic        r_err1;

   logic        w_sel1;
   logic        w_gnt0;
   logic        w_gnt1;
   logic        w_we;
   logic [31:0] w_addr;
   logic [31:0] w_wdata;
   logic        w_fault;
   logic        w_ce;

   // Arbitration and address check for the winning port; grants are held low
   // while reset is asserted so no command reaches the memory.
   always_comb begin
      w_sel1  = m1_req & (~m0_req | (r_starve_cnt == c_starve_max));
      w_gnt1  = rst & w_sel1;
      w_gnt0  = rst & m0_req & ~w_sel1;
      w_we    = w_sel1 ? m1_we    : m0_we;
      w_addr  = w_sel1 ? m1_addr  : m0_addr;
      w_wdata = w_sel1 ? m1_wdata : m0_wdata;
      // Shift keeps the range check valid for any ADDR_W up to 30.
      w_fault = (w_addr[1:0] != 2'b00) || ((w_addr >> (ADDR_W + 2)) != 32'd0);
      w_ce    = (w_gnt0 | w_gnt1) & ~w_fault;
   end

   assign m0_gnt  = w_gnt0;
   assign m1_gnt  = w_gnt1;
   assign mem_ce  = w_ce;
   assign mem_we  = w_ce & w_we;
   assign mem_ad  = w_ce ? w_addr[ADDR_W+1:2] : '0;
   assign mem_din = w_ce ? w_wdata : 32'd0;

   // Starvation counter: counts consecutive denied loader cycles, saturating.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_starve_cnt <= 4'd0;
      end else if (m1_req && !w_gnt1) begin
         if (r_starve_cnt != c_starve_max) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
         end
      end else begin
         r_starve_cnt <= 4'd0;
      end
   end

   // Response pipeline: remember who issued a read and which grant faulted.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rd_pend <= 1'b0;
         r_rd_sel  <= 1'b0;
         r_err0    <= 1'b0;
         r_err1    <= 1'b0;
      end else begin
         r_rd_pend <= w_ce & ~w_we;
         r_rd_sel  <= w_gnt1;
         r_err0    <= w_gnt0 & w_fault;
         r_err1    <= w_gnt1 & w_fault;
      end
   end

   assign m0_rvalid = r_rd_pend & ~r_rd_sel;
   assign m1_rvalid = r_rd_pend &  r_rd_sel;
   assign m0_rdata  = m0_rvalid ? mem_dout : 32'd0;
   assign m1_rdata  = m1_rvalid ? mem_dout : 32'd0;
   assign m0_err    = r_err0;
   assign m1_err    = r_err1;

endmodule
`default_nettype wire
